// File: rtl/nyan_sprite_render.sv
// Four-stage pixel pipeline that overlays a scaled, animated sprite from an
// external synchronous ROM onto the video stream, plus the animation sequencer.
module nyan_sprite_render #(
  parameter int          ORIGIN_X    = 192,
  parameter int          ORIGIN_Y    = 112,
  parameter int          SCALE_SHIFT = 2,
  parameter int          FRAMES      = 6,
  parameter int          FRAME_DIV   = 5,
  parameter logic [11:0] BG_COLOR    = 12'h036
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        activevideo,
  input  logic [9:0]  x_px,
  input  logic [9:0]  y_px,
  input  logic        anim_en,
  output logic [14:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic [11:0] rgb,
  output logic [2:0]  anim_frame,
  output logic        frame_tick
);

  localparam int SPAN = 64 << SCALE_SHIFT;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + SPAN);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + SPAN);
  localparam logic [7:0]  DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [2:0]  FRAME_LAST = 3'(FRAMES - 1);

  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h000, 12'hFFF, 12'hF9C, 12'hF3F, 12'hFC9, 12'hF00, 12'hF90,
    12'hFF0, 12'h3F0, 12'h09F, 12'h63F, 12'h999, 12'hF69, 12'h666, 12'hFCC
  };

  logic        hs_a, vs_a, act_a, vs_prev;
  logic        hs_b, vs_b, act_b, box_b;
  logic        hs_c, vs_c, act_c, box_c;
  logic [10:0] x_ext, y_ext;
  logic [5:0]  sx, sy;
  logic        in_box;
  logic        vsync_fall;
  logic [7:0]  div_cnt;

  // Bounds are checked on the unsubtracted coordinates so left/above never wrap in.
  assign x_ext  = {1'b0, x_px};
  assign y_ext  = {1'b0, y_px};
  assign in_box = act_a && (x_ext >= X_LO) && (x_ext < X_HI)
                        && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign sx = 6'((x_ext - X_LO) >> SCALE_SHIFT);
  assign sy = 6'((y_ext - Y_LO) >> SCALE_SHIFT);

  assign vsync_fall = vs_prev && !vs_a;

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hs_a    <= 1'b1;
      vs_a    <= 1'b1;
      act_a   <= 1'b0;
      vs_prev <= 1'b1;
    end else begin
      hs_a    <= hsync_in;
      vs_a    <= vsync_in;
      act_a   <= activevideo;
      vs_prev <= vs_a;
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hs_b     <= 1'b1;
      vs_b     <= 1'b1;
      act_b    <= 1'b0;
      box_b    <= 1'b0;
      rom_addr <= '0;
    end else begin
      hs_b  <= hs_a;
      vs_b  <= vs_a;
      act_b <= act_a;
      box_b <= in_box;
      if (in_box)
        rom_addr <= {anim_frame, sy, sx};
    end
  end

  // Stage C waits out the ROM read latency so rom_data lines up with box_c.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hs_c  <= 1'b1;
      vs_c  <= 1'b1;
      act_c <= 1'b0;
      box_c <= 1'b0;
    end else begin
      hs_c  <= hs_b;
      vs_c  <= vs_b;
      act_c <= act_b;
      box_c <= box_b;
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      active_out <= 1'b0;
      rgb        <= '0;
    end else begin
      hsync_out  <= hs_c;
      vsync_out  <= vs_c;
      active_out <= act_c;
      if (!act_c)
        rgb <= '0;
      else if (!box_c || rom_data == 4'd0)
        rgb <= BG_COLOR;
      else
        rgb <= PALETTE[rom_data];
    end
  end

  // Frame only advances at vsync fall, which is always in blanking.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      anim_frame <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (vsync_fall && anim_en) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt    <= '0;
          frame_tick <= 1'b1;
          anim_frame <= (anim_frame == FRAME_LAST) ? 3'd0 : anim_frame + 3'd1;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nyan_sprite_render.sv
// Directed bench for nyan_sprite_render: sync delay, sprite addressing, box
// edges, animation sequencing and asynchronous reset behaviour.
module tb_nyan_sprite_render;

  logic        px_clk;
  logic        reset;
  logic        hsync_in, vsync_in, activevideo;
  logic [9:0]  x_px, y_px;
  logic        anim_en;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data;
  logic        hsync_out, vsync_out, active_out;
  logic [11:0] rgb;
  logic [2:0]  anim_frame;
  logic        frame_tick;

  int checks_total  = 0;
  int checks_passed = 0;
  int tick_count    = 0;
  logic [9:0] prev_x = '0;
  logic [9:0] prev_y = '0;

  nyan_sprite_render dut (
    .px_clk     (px_clk),
    .reset      (reset),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .activevideo(activevideo),
    .x_px       (x_px),
    .y_px       (y_px),
    .anim_en    (anim_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .active_out (active_out),
    .rgb        (rgb),
    .anim_frame (anim_frame),
    .frame_tick (frame_tick)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  // Synchronous sprite ROM whose content is a simple function of the address.
  always @(posedge px_clk) rom_data <= rom_addr[3:0] ^ 4'd5;

  always @(negedge px_clk) if (frame_tick === 1'b1) tick_count++;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic [14:0] addr;
    logic [11:0] col;
    logic        act_out;
  } pix_t;

  // Frame 2 base address is 8192; ROM returns addr[3:0]^5.
  pix_t vecs [10] = '{
    '{10'd192, 10'd112, 1'b1, 15'd8192,  12'hFC9, 1'b1},
    '{10'd212, 10'd112, 1'b1, 15'd8197,  12'h036, 1'b1},
    '{10'd447, 10'd112, 1'b1, 15'd8255,  12'h09F, 1'b1},
    '{10'd448, 10'd112, 1'b1, 15'd8255,  12'h036, 1'b1},
    '{10'd191, 10'd112, 1'b1, 15'd8255,  12'h036, 1'b1},
    '{10'd192, 10'd367, 1'b1, 15'd12224, 12'hFC9, 1'b1},
    '{10'd192, 10'd368, 1'b1, 15'd12224, 12'h036, 1'b1},
    '{10'd192, 10'd111, 1'b1, 15'd12224, 12'h036, 1'b1},
    '{10'd196, 10'd112, 1'b0, 15'd12224, 12'h000, 1'b0},
    '{10'd0,   10'd0,   1'b1, 15'd12224, 12'h036, 1'b1}
  };

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      checks_passed++;
  endtask

  // Coordinates trail the sync/active flags by one cycle, like the sync generator.
  task automatic applyStimulus(input logic h, input logic v, input logic act,
                               input logic [9:0] x, input logic [9:0] y);
    @(negedge px_clk);
    hsync_in    = h;
    vsync_in    = v;
    activevideo = act;
    x_px        = prev_x;
    y_px        = prev_y;
    prev_x      = x;
    prev_y      = y;
    @(posedge px_clk);
  endtask

  task automatic vsyncPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
  endtask

  initial begin
    int base;
    logic exp_h;
    reset       = 1'b1;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    activevideo = 1'b0;
    x_px        = '0;
    y_px        = '0;
    anim_en     = 1'b0;

    repeat (3) @(posedge px_clk);
    #1;
    checkOutput("rst_hsync",  32'(hsync_out),  32'd1);
    checkOutput("rst_vsync",  32'(vsync_out),  32'd1);
    checkOutput("rst_active", 32'(active_out), 32'd0);
    checkOutput("rst_rgb",    32'(rgb),        32'd0);
    checkOutput("rst_addr",   32'(rom_addr),   32'd0);
    checkOutput("rst_frame",  32'(anim_frame), 32'd0);
    checkOutput("rst_tick",   32'(frame_tick), 32'd0);
    reset = 1'b0;

    // One-cycle hsync low must show up after exactly four clocks.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    #1 checkOutput("hs_delay1", 32'(hsync_out), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      exp_h = (i == 4) ? 1'b0 : 1'b1;
      #1 checkOutput($sformatf("hs_delay%0d", i), 32'(hsync_out), 32'(exp_h));
    end

    anim_en = 1'b1;
    base = tick_count;
    for (int k = 0; k < 6; k++) begin
      repeat (5) vsyncPulse();
      checkOutput($sformatf("anim_seq%0d", k), 32'(anim_frame), 32'((k + 1) % 6));
    end
    checkOutput("tick_count30", 32'(tick_count - base), 32'd6);

    anim_en = 1'b0;
    base = tick_count;
    repeat (10) vsyncPulse();
    checkOutput("hold_frame", 32'(anim_frame), 32'd0);
    checkOutput("hold_ticks", 32'(tick_count - base), 32'd0);

    anim_en = 1'b1;
    repeat (10) vsyncPulse();
    anim_en = 1'b0;
    checkOutput("frame_two", 32'(anim_frame), 32'd2);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].act, vecs[i].x, vecs[i].y);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      #1 checkOutput($sformatf("pix%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      #1;
      checkOutput($sformatf("pix%0d_rgb", i), 32'(rgb), 32'(vecs[i].col));
      checkOutput($sformatf("pix%0d_act", i), 32'(active_out), 32'(vecs[i].act_out));
    end

    // Mid-line reset: outputs must clear within the same cycle.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 10'(192 + 4 * i), 10'd112);
    #1;
    checkOutput("pre_rst_active", 32'(active_out), 32'd1);
    checkOutput("pre_rst_hsync",  32'(hsync_out),  32'd0);
    checkOutput("pre_rst_rgb",    32'(rgb),        32'hF3F);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_rgb",    32'(rgb),        32'd0);
    checkOutput("mid_rst_active", 32'(active_out), 32'd0);
    checkOutput("mid_rst_hsync",  32'(hsync_out),  32'd1);
    checkOutput("mid_rst_frame",  32'(anim_frame), 32'd0);
    checkOutput("mid_rst_addr",   32'(rom_addr),   32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd200, 10'd112);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd204, 10'd112);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 10'(208 + 4 * i), 10'd112);
    #1;
    checkOutput("flush_active3", 32'(active_out), 32'd0);
    checkOutput("flush_rgb3",    32'(rgb),        32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd220, 10'd112);
    #1 checkOutput("flush_active4", 32'(active_out), 32'd1);

    // vsync already low when reset releases counts as the first falling edge.
    anim_en  = 1'b1;
    reset    = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    #1 reset = 1'b0;
    base = tick_count;
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    repeat (4) vsyncPulse();
    checkOutput("post_rst_edge_frame", 32'(anim_frame), 32'd1);
    checkOutput("post_rst_edge_ticks", 32'(tick_count - base), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/nyan_sprite_render.md
NYAN_SPRITE_RENDER -- requirements
Module: nyan_sprite_render

Interface
REQ-001 SHALL have parameter ORIGIN_X, 192, left edge of scaled sprite in active pixels.
REQ-002 SHALL have parameter ORIGIN_Y, 112, top edge of scaled sprite in active lines.
REQ-003 SHALL have parameter SCALE_SHIFT, 2, sprite magnification as a power of two (2 = 4x).
REQ-004 SHALL have parameter FRAMES, 6, number of animation frames in the sprite ROM.
REQ-005 SHALL have parameter FRAME_DIV, 5, video frames shown per animation step.
REQ-006 SHALL have parameter BG_COLOR, 12'h036, RGB444 background colour.
REQ-007 SHALL have ports: px_clk  in  1  pixel clock (sole clock); reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports: hsync_in, vsync_in  in  1 each  active-low syncs from the sync generator.
REQ-009 SHALL have ports: activevideo  in  1  visible region flag, combinational at the sync generator.
REQ-010 SHALL have ports: x_px  in  10  and  y_px  in  10  registered pixel coordinates, one cycle behind activevideo/syncs.
REQ-011 SHALL have ports: anim_en  in  1  animation advance enable.
REQ-012 SHALL have ports: rom_addr  out  15  sprite ROM address; rom_data  in  4  palette index, valid one cycle after rom_addr.
REQ-013 SHALL have ports: hsync_out, vsync_out  out  1 each; active_out  out  1; rgb  out  12  RGB444 pixel.
REQ-014 SHALL have ports: anim_frame  out  3  current animation frame; frame_tick  out  1  one-cycle pulse on animation step.

Function
REQ-015 Stage A SHALL register hsync_in, vsync_in, activevideo once, aligning them with x_px/y_px.
REQ-016 Stage B SHALL compute in_box = activeA and x in [ORIGIN_X, ORIGIN_X+(64<<SCALE_SHIFT)) and y in [ORIGIN_Y, ORIGIN_Y+(64<<SCALE_SHIFT)).
REQ-017 Stage B SHALL register rom_addr = anim_frame*4096 + sy*64 + sx, sx=(x-ORIGIN_X)>>SCALE_SHIFT, sy=(y-ORIGIN_Y)>>SCALE_SHIFT, 6 bits each.
REQ-018 Outside in_box, rom_addr SHALL hold its previous value.
REQ-019 Stage D SHALL register rgb: 0 when not active; BG_COLOR when active and (not in_box or rom_data==0); palette[rom_data] otherwise.
REQ-020 Palette SHALL be a fixed 16-entry RGB444 table; entry 0 is transparent.
REQ-021 hsync_out, vsync_out, active_out SHALL equal hsync_in, vsync_in, activevideo delayed exactly 4 px_clk cycles; rgb aligned with active_out.
REQ-022 in_box SHALL be carried through the pipeline alongside the syncs, with no bubbles or stalls.
REQ-023 A vsync falling edge SHALL be detected on stage-A vsync (prev 1, now 0).
REQ-024 On that edge with anim_en=1, a divider SHALL count 0..FRAME_DIV-1; on wrap, anim_frame SHALL increment (FRAMES-1 -> 0) and frame_tick SHALL pulse for exactly one cycle.
REQ-025 With anim_en=0, the divider and anim_frame SHALL hold, and frame_tick SHALL stay 0.
REQ-026 anim_frame SHALL change only at vsync falling edge, never during active video, so no frame tears.
REQ-027 Coordinates outside the box SHALL never wrap into it; compare before subtraction.

Reset
REQ-028 While reset=1, all registers SHALL clear asynchronously: hsync_out=1, vsync_out=1, active_out=0, rgb=0, rom_addr=0, anim_frame=0, frame_tick=0, divider=0.
REQ-029 The stage-A vsync history SHALL reset to 1, so a low vsync_in right after reset counts as one falling edge.
REQ-030 Reset asserted mid-line SHALL flush the pipeline; outputs SHALL stay at reset values until new inputs propagate (4 cycles).

Verification
REQ-031 Toggle hsync_in low for 1 cycle at t -> hsync_out low exactly at t+4, high otherwise.
REQ-032 x_px=ORIGIN_X, y_px=ORIGIN_Y, active, anim_frame=2 -> rom_addr=8192 one cycle later; rom_data=5 -> rgb=palette[5] at t+4.
REQ-033 x_px=ORIGIN_X+255 / ORIGIN_X+256 on the sprite row -> sx=63 in box / out of box, rgb=BG_COLOR.
REQ-034 rom_data=0 inside box -> rgb=BG_COLOR; activevideo=0 -> rgb=0.
REQ-035 30 vsync pulses with anim_en=1 -> 6 frame_tick pulses, anim_frame sequence 1,2,3,4,5,0; with anim_en=0 -> anim_frame constant.
REQ-036 Assert reset during active video -> rgb=0, active_out=0, hsync_out=1 in the same cycle (asynchronous), anim_frame=0.
